// File: rtl/rsa_pkg.sv
// Shared types and sizes for the RSA modular exponentiation controller.
//   WIDTH : operand width (B, E, M, R2 and every MMM operand)
//   LEN_W : width of the len field, able to hold 1..WIDTH
//   IDX_W : width of the exponent bit index, 0..WIDTH-1
//   state_t : sequencer states
package rsa_pkg;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned LEN_W = $clog2(WIDTH) + 1;
   localparam int unsigned IDX_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TO_B = 3'd1,
      TO_A = 3'd2,
      SQR  = 3'd3,
      MUL  = 3'd4,
      FROM = 3'd5,
      RESP = 3'd6
   } state_t;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing Z = B^E mod M on a
// shared external Montgomery multiplier (MMM, Z = X*Y*R^-1 mod M).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_base/exp/mod/r2/len    B, E, M, R^2 mod M, len (R = 2^len)
//   rsp_valid/rsp_ready        response handshake
//   rsp_result                 B^E mod M
//   busy                       high outside IDLE
//   mm_start, mm_x, mm_y       MMM launch pulse and operands (held until mm_done)
//   mm_m, mm_len               MMM modulus and iteration count
//   mm_done, mm_z              MMM completion pulse and result
// Build option: EXP_SKIP_LZ_EN skips squarings on leading zero exponent bits.
module mod_exp_ctrl
   import rsa_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_base,
   input  logic [WIDTH-1:0] req_exp,
   input  logic [WIDTH-1:0] req_mod,
   input  logic [WIDTH-1:0] req_r2,
   input  logic [LEN_W-1:0] req_len,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             busy,
   output logic             mm_start,
   output logic [WIDTH-1:0] mm_x,
   output logic [WIDTH-1:0] mm_y,
   output logic [WIDTH-1:0] mm_m,
   output logic [31:0]      mm_len,
   input  logic             mm_done,
   input  logic [WIDTH-1:0] mm_z
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t state_q, state_d;

   // b_q holds B until TO_B completes, then the Montgomery-domain bbar
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] e_q, e_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] r2_q, r2_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mm_x_q, mm_x_d;
   logic [WIDTH-1:0] mm_y_q, mm_y_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             issued_q, issued_d;
   logic             mm_start_q, mm_start_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             req_ready_q, req_ready_d;
   logic             busy_q, busy_d;
`ifdef EXP_SKIP_LZ_EN
   logic             seen_q, seen_d;
`endif

   logic e_bit_c, last_bit_c, op_done_c, accept_c, op_state_c, skip_c;

   assign e_bit_c    = e_q[idx_q];
   assign last_bit_c = (idx_q == '0);
   // issued_q filters out mm_done pulses with no operation outstanding
   assign op_done_c  = issued_q & mm_done;
   assign accept_c   = (state_q == IDLE) & req_valid & req_ready_q;
   assign op_state_c = (state_q == TO_B) | (state_q == TO_A) | (state_q == SQR) |
                       (state_q == MUL)  | (state_q == FROM);

`ifdef EXP_SKIP_LZ_EN
   // Squaring R mod M is the identity, so leading zero bits need no op
   assign skip_c = (state_q == SQR) & ~issued_q & ~seen_q & ~e_bit_c;
`else
   assign skip_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept_c) state_d = TO_B;
         TO_B: if (op_done_c) state_d = TO_A;
         TO_A: if (op_done_c) state_d = SQR;
         SQR: begin
            if (skip_c) begin
               if (last_bit_c) state_d = FROM;
            end else if (op_done_c) begin
               if (e_bit_c)         state_d = MUL;
               else if (last_bit_c) state_d = FROM;
            end
         end
         MUL:  if (op_done_c) state_d = last_bit_c ? FROM : SQR;
         FROM: if (op_done_c) state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next-state logic
   always_comb begin
      b_d          = b_q;
      e_d          = e_q;
      m_d          = m_q;
      r2_d         = r2_q;
      acc_d        = acc_q;
      mm_x_d       = mm_x_q;
      mm_y_d       = mm_y_q;
      rsp_result_d = rsp_result_q;
      len_d        = len_q;
      idx_d        = idx_q;
      issued_d     = issued_q;
      mm_start_d   = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      req_ready_d  = req_ready_q;
      busy_d       = busy_q;
`ifdef EXP_SKIP_LZ_EN
      seen_d       = seen_q;
`endif

      if (accept_c) begin
         b_d         = req_base;
         e_d         = req_exp;
         m_d         = req_mod;
         r2_d        = req_r2;
         len_d       = req_len;
         idx_d       = IDX_W'(req_len - LEN_W'(1));
         acc_d       = '0;
         req_ready_d = 1'b0;
         busy_d      = 1'b1;
`ifdef EXP_SKIP_LZ_EN
         seen_d      = 1'b0;
`endif
      end

      // Launch one MMM op per visit of an op state
      if (op_state_c && !issued_q && !skip_c) begin
         mm_start_d = 1'b1;
         issued_d   = 1'b1;
         case (state_q)
            TO_B: begin mm_x_d = b_q;   mm_y_d = r2_q;  end
            TO_A: begin mm_x_d = ONE;   mm_y_d = r2_q;  end
            SQR: begin
               mm_x_d = acc_q;
               mm_y_d = acc_q;
`ifdef EXP_SKIP_LZ_EN
               seen_d = 1'b1;
`endif
            end
            MUL:     begin mm_x_d = acc_q; mm_y_d = b_q; end
            default: begin mm_x_d = acc_q; mm_y_d = ONE; end
         endcase
      end

      // Capture the MMM result and advance the bit index
      if (op_done_c) begin
         issued_d = 1'b0;
         case (state_q)
            TO_B: b_d = mm_z;
            SQR: begin
               acc_d = mm_z;
               if (!e_bit_c && !last_bit_c) idx_d = IDX_W'(idx_q - IDX_W'(1));
            end
            MUL: begin
               acc_d = mm_z;
               if (!last_bit_c) idx_d = IDX_W'(idx_q - IDX_W'(1));
            end
            FROM: begin
               acc_d        = mm_z;
               rsp_result_d = mm_z;
               rsp_valid_d  = 1'b1;
            end
            default: acc_d = mm_z;
         endcase
      end

      if (skip_c && !last_bit_c) idx_d = IDX_W'(idx_q - IDX_W'(1));

      if ((state_q == RESP) && rsp_ready) begin
         rsp_valid_d = 1'b0;
         req_ready_d = 1'b1;
         busy_d      = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b_q          <= '0;
         e_q          <= '0;
         m_q          <= '0;
         r2_q         <= '0;
         acc_q        <= '0;
         mm_x_q       <= '0;
         mm_y_q       <= '0;
         rsp_result_q <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         issued_q     <= 1'b0;
         mm_start_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
`ifdef EXP_SKIP_LZ_EN
         seen_q       <= 1'b0;
`endif
      end else begin
         b_q          <= b_d;
         e_q          <= e_d;
         m_q          <= m_d;
         r2_q         <= r2_d;
         acc_q        <= acc_d;
         mm_x_q       <= mm_x_d;
         mm_y_q       <= mm_y_d;
         rsp_result_q <= rsp_result_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         issued_q     <= issued_d;
         mm_start_q   <= mm_start_d;
         rsp_valid_q  <= rsp_valid_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
`ifdef EXP_SKIP_LZ_EN
         seen_q       <= seen_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign busy       = busy_q;
   assign mm_start   = mm_start_q;
   assign mm_x       = mm_x_q;
   assign mm_y       = mm_y_q;
   assign mm_m       = m_q;
   assign mm_len     = 32'(len_q);

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: behavioural Montgomery multiplier with
// configurable latency, table-driven vectors, hand-written corner sequences and
// a randomised len=64 run against a software modpow. Expected op counts follow
// the EXP_SKIP_LZ_EN build option.
module tb_mod_exp_ctrl;
   import rsa_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_base, req_exp, req_mod, req_r2;
   logic [LEN_W-1:0] req_len;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             busy;
   logic             mm_start;
   logic [WIDTH-1:0] mm_x, mm_y, mm_m;
   logic [31:0]      mm_len;
   logic             mm_done;
   logic [WIDTH-1:0] mm_z;

   mod_exp_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_base(req_base), .req_exp(req_exp), .req_mod(req_mod),
      .req_r2(req_r2), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .busy(busy),
      .mm_start(mm_start), .mm_x(mm_x), .mm_y(mm_y), .mm_m(mm_m),
      .mm_len(mm_len), .mm_done(mm_done), .mm_z(mm_z)
   );

   typedef struct {
      logic [63:0] base, expn, modl, r2;
      int          len;
      logic [63:0] res;
      int          ops_plain, ops_skip, lat;
      bit          early;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      int          ops;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          op_cnt   = 0;
   int          ops_base = 0;
   int          lat_cfg  = 1;
   bit          spur_req = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mont(input logic [63:0] x, input logic [63:0] y,
                                        input logic [63:0] m, input int len);
      logic [65:0] a;
      a = '0;
      for (int i = 0; i < len; i++) begin
         if (x[i]) a = a + {2'b00, y};
         if (a[0]) a = a + {2'b00, m};
         a = a >> 1;
      end
      if (a >= {2'b00, m}) a = a - {2'b00, m};
      return a[63:0];
   endfunction

   function automatic logic [63:0] modpow(input logic [63:0] b, input logic [63:0] e,
                                          input logic [63:0] m, input int len);
      logic [127:0] r, bb, mm;
      mm = {64'd0, m};
      r  = 128'd1 % mm;
      bb = {64'd0, b} % mm;
      for (int i = len - 1; i >= 0; i--) begin
         r = (r * r) % mm;
         if (e[i]) r = (r * bb) % mm;
      end
      return r[63:0];
   endfunction

   function automatic logic [63:0] r2_ref(input logic [63:0] m, input int len);
      logic [64:0] r;
      r = 65'd1 % {1'b0, m};
      for (int i = 0; i < 2 * len; i++) begin
         r = r << 1;
         if (r >= {1'b0, m}) r = r - {1'b0, m};
      end
      return r[63:0];
   endfunction

   function automatic int calc_ops(input logic [63:0] e, input int len);
      int pop, msb;
      pop = 0;
      msb = -1;
      for (int i = 0; i < len; i++) if (e[i]) begin pop++; msb = i; end
`ifdef EXP_SKIP_LZ_EN
      return (msb < 0) ? 3 : 3 + msb + 1 + pop;
`else
      return 3 + len + pop;
`endif
   endfunction

   // Behavioural MMM: latency lat_cfg cycles from mm_start to the mm_done pulse
   initial begin
      logic [63:0] sx, sy, sm, zexp;
      int          cnt, stab_err;
      bit          busy_mm;
      mm_done = 1'b0;
      mm_z    = '0;
      busy_mm = 1'b0;
      cnt = 0; stab_err = 0; sx = '0; sy = '0; sm = '0; zexp = '0;
      forever begin
         tick();
         mm_done = 1'b0;
         if (!rst_n) begin
            busy_mm = 1'b0;
         end else begin
            if (busy_mm) begin
               if (mm_x !== sx || mm_y !== sy || mm_m !== sm) stab_err++;
               if (cnt == 0) begin
                  mm_done = 1'b1;
                  mm_z    = zexp;
                  busy_mm = 1'b0;
                  check("mm operands stable", 64'(stab_err), 64'd0);
               end else begin
                  cnt--;
               end
            end else if (spur_req) begin
               mm_done  = 1'b1;
               mm_z     = 64'hDEAD_BEEF_0BAD_F00D;
               spur_req = 1'b0;
            end
            if (mm_start) begin
               check("mm_start while op outstanding", 64'(busy_mm), 64'd0);
               op_cnt++;
               sx = mm_x; sy = mm_y; sm = mm_m;
               zexp     = mont(mm_x, mm_y, mm_m, int'(mm_len));
               stab_err = 0;
               cnt      = lat_cfg - 1;
               busy_mm  = 1'b1;
            end
         end
      end
   end

   task automatic check_reset_vals();
      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset busy", 64'(busy), 64'd0);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_result", rsp_result, 64'd0);
      check("reset mm_start", 64'(mm_start), 64'd0);
      check("reset mm_x", mm_x, 64'd0);
      check("reset mm_y", mm_y, 64'd0);
      check("reset mm_m", mm_m, 64'd0);
      check("reset mm_len", 64'(mm_len), 64'd0);
   endtask

   function automatic int vec_ops(input vec_t v);
`ifdef EXP_SKIP_LZ_EN
      return v.ops_skip;
`else
      return v.ops_plain;
`endif
   endfunction

   task automatic drive_fields(input vec_t v);
      req_base = v.base;
      req_exp  = v.expn;
      req_mod  = v.modl;
      req_r2   = v.r2;
      req_len  = LEN_W'(v.len);
   endtask

   task automatic send_req(input vec_t v);
      exp_t e;
      int   t;
      t = 0;
      while (!req_ready && t < 20000) begin tick(); t++; end
      check("req_ready before request", 64'(req_ready), 64'd1);
      drive_fields(v);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      ops_base  = op_cnt;
      e.res = v.res;
      e.ops = vec_ops(v);
      exp_q.push_back(e);
      check("req_ready low after accept", 64'(req_ready), 64'd0);
   endtask

   task automatic get_rsp();
      exp_t e;
      int   t;
      t = 0;
      while (!rsp_valid && t < 20000) begin tick(); t++; end
      check("rsp_valid arrives", 64'(rsp_valid), 64'd1);
      check("scoreboard has entry", 64'(exp_q.size() > 0), 64'd1);
      if (rsp_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rsp_result", rsp_result, e.res);
         check("mm op count", 64'(op_cnt - ops_base), 64'(e.ops));
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         check("rsp_valid drops after handshake", 64'(rsp_valid), 64'd0);
         check("req_ready back in IDLE", 64'(req_ready), 64'd1);
      end
   endtask

   initial begin
      vec_t vecs[8];
      vec_t v, v2;
      logic [63:0] r0;
      int   ops_hold, t;

      vecs[0] = '{base:64'd4,  expn:64'd13,    modl:64'd13,  r2:64'd9,  len:4, res:64'd4,
                  ops_plain:10, ops_skip:10, lat:1, early:1'b0};
      vecs[1] = '{base:64'd3,  expn:64'd5,     modl:64'd13,  r2:64'd9,  len:4, res:64'd9,
                  ops_plain:9,  ops_skip:8,  lat:3, early:1'b0};
      vecs[2] = '{base:64'd7,  expn:64'd0,     modl:64'd13,  r2:64'd9,  len:4, res:64'd1,
                  ops_plain:7,  ops_skip:3,  lat:7, early:1'b1};
      vecs[3] = '{base:64'd0,  expn:64'd13,    modl:64'd1,   r2:64'd0,  len:4, res:64'd0,
                  ops_plain:10, ops_skip:10, lat:2, early:1'b0};
      vecs[4] = '{base:64'd5,  expn:64'd6,     modl:64'd1,   r2:64'd0,  len:3, res:64'd0,
                  ops_plain:8,  ops_skip:8,  lat:1, early:1'b0};
      vecs[5] = '{base:64'd2,  expn:64'd31,    modl:64'd31,  r2:64'd1,  len:5, res:64'd2,
                  ops_plain:13, ops_skip:13, lat:2, early:1'b1};
      vecs[6] = '{base:64'd10, expn:64'd3,     modl:64'd251, r2:64'd25, len:8, res:64'd247,
                  ops_plain:13, ops_skip:7,  lat:4, early:1'b0};
      vecs[7] = '{base:64'd4,  expn:64'hF0D,   modl:64'd13,  r2:64'd9,  len:4, res:64'd4,
                  ops_plain:10, ops_skip:10, lat:1, early:1'b0};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_base = '0; req_exp = '0; req_mod = '0; req_r2 = '0; req_len = '0;
      repeat (3) tick();
      check_reset_vals();
      rst_n = 1'b1;
      tick();

      // Stray mm_done in IDLE must be ignored
      spur_req = 1'b1;
      repeat (3) tick();
      check("stray mm_done in IDLE: busy", 64'(busy), 64'd0);
      check("stray mm_done in IDLE: mm_start", 64'(mm_start), 64'd0);

      foreach (vecs[k]) begin
         lat_cfg = vecs[k].lat;
         if (vecs[k].early) rsp_ready = 1'b1;
         send_req(vecs[k]);
         get_rsp();
      end

      // Response backpressure, blocked second request, stray mm_done in RESP
      lat_cfg = 2;
      v  = vecs[0];
      v2 = vecs[1];
      send_req(v);
      t = 0;
      while (!rsp_valid && t < 20000) begin tick(); t++; end
      check("hold: rsp_valid arrives", 64'(rsp_valid), 64'd1);
      r0       = rsp_result;
      ops_hold = op_cnt;
      drive_fields(v2);
      req_valid = 1'b1;
      spur_req  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("hold rsp_valid", 64'(rsp_valid), 64'd1);
         check("hold rsp_result", rsp_result, r0);
         check("hold req_ready", 64'(req_ready), 64'd0);
      end
      check("hold: no new op", 64'(op_cnt - ops_hold), 64'd0);
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("hold result", r0, e.res);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("release: rsp_valid drops", 64'(rsp_valid), 64'd0);
      check("release: req_ready", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      ops_base  = op_cnt;
      begin
         exp_t e;
         e.res = v2.res;
         e.ops = vec_ops(v2);
         exp_q.push_back(e);
      end
      check("second request accepted: busy", 64'(busy), 64'd1);
      check("second request accepted: req_ready", 64'(req_ready), 64'd0);
      get_rsp();

      // Reset in the middle of the first squaring, then a fresh request
      send_req(v2);
      t = 0;
      while ((op_cnt - ops_base) < 3 && t < 2000) begin tick(); t++; end
      check("reached first SQR op", 64'(op_cnt - ops_base), 64'd3);
      rst_n = 1'b0;
      tick();
      check_reset_vals();
      tick();
      rst_n = 1'b1;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
      send_req(v2);
      get_rsp();

      // Full-width random operands against a software modpow
      for (int n = 0; n < 40; n++) begin
         vec_t r;
         r.len  = 64;
         r.modl = {$urandom(), $urandom()} | 64'd1;
         if (r.modl == 64'd1) r.modl = 64'd3;
         r.base = {$urandom(), $urandom()} % r.modl;
         r.expn = {$urandom(), $urandom()};
         r.r2   = r2_ref(r.modl, r.len);
         r.res  = modpow(r.base, r.expn, r.modl, r.len);
         r.ops_plain = calc_ops(r.expn, r.len);
         r.ops_skip  = r.ops_plain;
         r.early = 1'b0;
         r.lat   = (n % 10 == 0) ? r.len + 3 : int'($urandom_range(3, 1));
         lat_cfg = r.lat;
         send_req(r);
         get_rsp();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
